nios2_key_in: RTL
=================

NIOS2_KEY_IN -- requirements
Module: nios2_key_in

Interface
REQ-001 The block SHALL use parameter WIDTH, default 4, as the number of key input bits (1..32).
REQ-002 The block SHALL use parameter DEBOUNCE_CYCLES, default 50000, as the number of stable clk cycles required to accept a level change (>=1).
REQ-003 The block SHALL use parameter EDGE_TYPE, default 1, to select edge capture: 0 = rising, 1 = falling, 2 = any.
REQ-004 The block SHALL use parameter IDLE_LEVEL, default 1, as the level loaded into every input bit at reset (key released).
REQ-005 Port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port address, input, 2 bits: Avalon-MM word address.
REQ-008 Port chipselect, input, 1 bit: slave select.
REQ-009 Port write_n, input, 1 bit: active-low write strobe.
REQ-010 Port writedata, input, 32 bits: write data.
REQ-011 Port readdata, output, 32 bits: registered read data.
REQ-012 Port in_port, input, WIDTH bits: asynchronous key inputs.
REQ-013 Port irq, output, 1 bit: level interrupt request.

Function
REQ-014 Each in_port bit SHALL pass through a 2-flop synchronizer; sync output lags in_port by 2 cycles.
REQ-015 A per-bit debouncer SHALL have a counter and a debounced register; while sync != debounced, the counter increments each cycle, and any cycle with sync == debounced clears it to 0.
REQ-016 When the counter reaches DEBOUNCE_CYCLES-1 with sync still != debounced, the debounced bit SHALL take the sync value on the next edge and the counter SHALL clear; a glitch shorter than DEBOUNCE_CYCLES SHALL never reach the debounced register.
REQ-017 Edge detect SHALL compare debounced with its 1-cycle-delayed copy: rising = 0->1, falling = 1->0, any = either, per EDGE_TYPE.
REQ-018 Register map: addr 0 = data (RO, debounced), addr 1 = reserved (reads 0, writes ignored), addr 2 = irq_mask (RW, WIDTH bits), addr 3 = edge_capture (read, write-1-to-clear per bit).
REQ-019 A write SHALL occur when chipselect=1 and write_n=0; addr 2 loads irq_mask <= writedata[WIDTH-1:0].
REQ-020 For addr 3 writes, each edge_capture bit with writedata=1 SHALL clear, and bits with writedata=0 SHALL be unchanged.
REQ-021 An edge event SHALL set its edge_capture bit, which holds until cleared; if set and clear hit one bit in the same cycle, set SHALL win.
REQ-022 readdata SHALL be registered every cycle from the mux output of address, giving read latency 1 with no wait states; unused upper bits SHALL be 0.
REQ-023 irq SHALL equal OR of (edge_capture & irq_mask), computed combinationally from registers; masking a pending bit SHALL drop irq without clearing edge_capture.
REQ-024 Latency SHALL be: in_port change to edge_capture set = 2 (sync) + DEBOUNCE_CYCLES + 1 (edge register) cycles; irq asserts in that same cycle.
REQ-025 Debounce counter width SHALL be clog2(DEBOUNCE_CYCLES+1), and the counter SHALL never wrap.

Reset
REQ-026 While reset=1, sync flops, debounced and delayed registers SHALL load IDLE_LEVEL for all bits; counters, irq_mask, edge_capture and readdata SHALL load 0; irq SHALL be 0.
REQ-027 Reset asserted mid-debounce SHALL abort the count, and no edge SHALL be reported after reset release unless the input then differs from IDLE_LEVEL for DEBOUNCE_CYCLES.
REQ-028 Any write in a reset cycle SHALL be ignored.

Verification (DEBOUNCE_CYCLES=4, WIDTH=4, EDGE_TYPE=1)
REQ-029 Hold in_port=4'hF, release reset, then read addr 0 -> readdata=0x0000000F, and irq=0 for 100 cycles.
REQ-030 Drop in_port[0] to 0 and hold it -> edge_capture=0x1 exactly 7 cycles later; with irq_mask=0x1 set, irq=1 in that cycle.
REQ-031 Pulse in_port[1] low for 3 cycles -> data and edge_capture unchanged, and irq stays 0.
REQ-032 With edge_capture=0x3, write 0x1 to addr 3 -> edge_capture=0x2; then write 0x0 to addr 2 -> irq=0 and edge_capture still 0x2.
REQ-033 Complete a falling edge on bit 2 in the same cycle as a write of 0x4 to addr 3 -> edge_capture[2]=1.
REQ-034 Assert reset for 1 cycle while the bit 3 counter=2 -> counter=0 and irq_mask=0; holding in_port[3]=0 then sets edge_capture[3] 7 cycles after release.

Source files
------------

// File: rtl/nios2_key_in.sv
// Debounced key input port with edge capture and a maskable level IRQ.
// Ports: clk, reset (sync, active-high); Avalon-MM slave address,
//   chipselect, write_n, writedata, readdata (latency 1);
//   in_port (async keys); irq (OR of edge_capture & irq_mask).
module nios2_key_in #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_TYPE       = 1,
   parameter bit IDLE_LEVEL      = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0] IDLE = {WIDTH{IDLE_LEVEL}};

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_deb;
   logic [WIDTH-1:0] r_deb_d;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_edge_cap;
   logic [CW-1:0]    r_cnt [WIDTH];
   logic [31:0]      r_readdata;

   logic             w_wr;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clr;
   logic [31:0]      w_rdmux;
   logic             w_unused_wd;

   assign w_wr = chipselect & ~write_n;
   assign w_unused_wd = ^writedata;

   always_comb begin
      w_edge = '0;
      if (EDGE_TYPE == 0)
         w_edge = r_deb & ~r_deb_d;
      else if (EDGE_TYPE == 1)
         w_edge = ~r_deb & r_deb_d;
      else
         w_edge = r_deb ^ r_deb_d;
   end

   always_comb begin
      w_clr = '0;
      if (w_wr && address == 2'd3)
         w_clr = writedata[WIDTH-1:0];
   end

   always_comb begin
      w_rdmux = '0;
      case (address)
         2'd0:    w_rdmux[WIDTH-1:0] = r_deb;
         2'd2:    w_rdmux[WIDTH-1:0] = r_mask;
         2'd3:    w_rdmux[WIDTH-1:0] = r_edge_cap;
         default: w_rdmux = '0;
      endcase
   end

   // Synchronizer and per-bit debounce counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= IDLE;
         r_sync2 <= IDLE;
         r_deb   <= IDLE;
         r_deb_d <= IDLE;
         for (int i = 0; i < WIDTH; i++)
            r_cnt[i] <= '0;
      end else begin
         r_sync1 <= in_port;
         r_sync2 <= r_sync1;
         r_deb_d <= r_deb;
         for (int i = 0; i < WIDTH; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_deb[i] <= r_sync2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   // Register file; a new edge wins over a same-cycle clear
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mask     <= '0;
         r_edge_cap <= '0;
         r_readdata <= '0;
      end else begin
         if (w_wr && address == 2'd2)
            r_mask <= writedata[WIDTH-1:0];
         r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
         r_readdata <= w_rdmux;
      end
   end

   assign readdata = r_readdata;
   assign irq      = |(r_edge_cap & r_mask);

endmodule
